// File: rtl/fhe_acc_pkg.sv
// Shared FHE accelerator definitions: left-shifter defaults and beat payload.
package fhe_acc_pkg;

  localparam int unsigned LSHIFT_BIT_WIDTH = 108;
  localparam int unsigned LSHIFT_K_WIDTH   = 7;
  localparam int unsigned LSHIFT_TAG_WIDTH = 8;

  // One beat travelling through the left-shift pipe
  typedef struct packed {
    logic [LSHIFT_BIT_WIDTH-1:0] data;
    logic [LSHIFT_K_WIDTH-1:0]   k;
    logic                        ovf;
    logic [LSHIFT_TAG_WIDTH-1:0] tag;
  } lshift_beat_t;

endpackage

// File: rtl/lshift_stage.sv
// One pipe stage: conditional left shift by 2^STAGE with shifted-out detection.
module lshift_stage
  import fhe_acc_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = LSHIFT_BIT_WIDTH,
  parameter int unsigned K_WIDTH   = LSHIFT_K_WIDTH,
  parameter int unsigned TAG_WIDTH = LSHIFT_TAG_WIDTH,
  parameter int unsigned STAGE     = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 up_valid,
  input  logic [BIT_WIDTH-1:0] up_data,
  input  logic [K_WIDTH-1:0]   up_k,
  input  logic                 up_ovf,
  input  logic [TAG_WIDTH-1:0] up_tag,
  output logic                 valid,
  output logic [BIT_WIDTH-1:0] data,
  output logic [K_WIDTH-1:0]   k,
  output logic                 ovf,
  output logic [TAG_WIDTH-1:0] tag
);

  localparam int unsigned SHIFT = 32'd1 << STAGE;

  logic [BIT_WIDTH-1:0] shifted;
  logic                 lost;
  logic [BIT_WIDTH-1:0] data_n;
  logic                 ovf_n;

  // Shifted operand and OR of the bits pushed off the top
  if (SHIFT < BIT_WIDTH) begin : g_part
    assign shifted = up_data << SHIFT;
    assign lost    = |up_data[BIT_WIDTH-1 -: SHIFT];
  end else begin : g_full
    assign shifted = '0;
    assign lost    = |up_data;
  end

  // Select shifted or pass-through and accumulate overflow
  always_comb begin
    data_n = up_data;
    ovf_n  = up_ovf;
    if (up_k[STAGE]) begin
      data_n = shifted;
      ovf_n  = up_ovf | lost;
    end
  end

  // Stage register; loads whenever this slot is free or draining
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      k     <= '0;
      ovf   <= 1'b0;
      tag   <= '0;
    end else if (load) begin
      valid <= up_valid;
      data  <= data_n;
      k     <= up_k;
      ovf   <= ovf_n;
      tag   <= up_tag;
    end
  end

endmodule

// File: rtl/lshift_pipe.sv
// Pipelined valid/ready logical left barrel shifter with overflow flag and tag.
module lshift_pipe
  import fhe_acc_pkg::*;
#(
  parameter int unsigned BIT_WIDTH   = LSHIFT_BIT_WIDTH,
  parameter int unsigned SHIFT_WIDTH = LSHIFT_K_WIDTH,
  parameter int unsigned TAG_WIDTH   = LSHIFT_TAG_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BIT_WIDTH-1:0]   in_data,
  input  logic [SHIFT_WIDTH-1:0] in_k,
  input  logic [TAG_WIDTH-1:0]   in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BIT_WIDTH-1:0]   out_data,
  output logic                   out_ovf,
  output logic [TAG_WIDTH-1:0]   out_tag
);

  // Index 0 is the input port, index i+1 is the output of stage i
  logic [SHIFT_WIDTH:0]   v;
  logic [BIT_WIDTH-1:0]   d_a [0:SHIFT_WIDTH];
  logic [SHIFT_WIDTH-1:0] k_a [0:SHIFT_WIDTH];
  logic                   o_a [0:SHIFT_WIDTH];
  logic [TAG_WIDTH-1:0]   t_a [0:SHIFT_WIDTH];
  logic [SHIFT_WIDTH-1:0] rdy;
  logic [SHIFT_WIDTH-1:0] k_tail_unused;

  assign v[0]   = in_valid;
  assign d_a[0] = in_data;
  assign k_a[0] = in_k;
  assign o_a[0] = 1'b0;
  assign t_a[0] = in_tag;

  for (genvar i = 0; i < SHIFT_WIDTH; i++) begin : g_stage
    // Stage i may load if any slot from i onward is empty or the consumer takes a beat
    assign rdy[i] = out_ready | ~(&v[SHIFT_WIDTH:i+1]);

    lshift_stage #(
      .BIT_WIDTH (BIT_WIDTH),
      .K_WIDTH   (SHIFT_WIDTH),
      .TAG_WIDTH (TAG_WIDTH),
      .STAGE     (i)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .load     (rdy[i]),
      .up_valid (v[i]),
      .up_data  (d_a[i]),
      .up_k     (k_a[i]),
      .up_ovf   (o_a[i]),
      .up_tag   (t_a[i]),
      .valid    (v[i+1]),
      .data     (d_a[i+1]),
      .k        (k_a[i+1]),
      .ovf      (o_a[i+1]),
      .tag      (t_a[i+1])
    );
  end

  // Output port is the last stage register; the remaining shift amount is spent there
  assign in_ready      = rdy[0];
  assign out_valid     = v[SHIFT_WIDTH];
  assign out_data      = d_a[SHIFT_WIDTH];
  assign out_ovf       = o_a[SHIFT_WIDTH];
  assign out_tag       = t_a[SHIFT_WIDTH];
  assign k_tail_unused = k_a[SHIFT_WIDTH];

endmodule

// File: tb/tb_lshift_pipe.sv
// Self-checking bench for lshift_pipe with a scoreboard queue.
module tb_lshift_pipe;
  import fhe_acc_pkg::*;

  localparam int unsigned BW    = 108;
  localparam int unsigned KW    = 7;
  localparam int unsigned TW    = 8;
  localparam int unsigned DEPTH = 7;
  localparam int unsigned FW    = BW + 128;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_data;
  logic [KW-1:0] in_k;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;
  logic          out_ovf;
  logic [TW-1:0] out_tag;

  int n_tests = 0;
  int n_fail  = 0;
  lshift_beat_t sb[$];

  lshift_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_k      (in_k),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: shift into a wide field, low part is the result, high part is lost bits
  function automatic lshift_beat_t model(input logic [BW-1:0] d, input logic [KW-1:0] k,
                                         input logic [TW-1:0] t);
    logic [FW-1:0] full;
    lshift_beat_t  r;
    full   = FW'(d) << k;
    r.data = full[BW-1:0];
    r.ovf  = |full[FW-1:BW];
    r.k    = k;
    r.tag  = t;
    return r;
  endfunction

  function automatic logic [BW-1:0] rand_data();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return BW'(r);
  endfunction

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Scoreboard monitor: compares output beats and records accepted inputs
  always @(negedge clk) begin
    lshift_beat_t e;
    if (rst) begin
      sb.delete();
    end else begin
      check("in_ready", in_ready, (sb.size() < DEPTH) || out_ready);
      if (sb.size() == 0) begin
        check("no_spurious_valid", out_valid, 1'b0);
      end else if (out_valid) begin
        e = sb[0];
        check("out_data", out_data, e.data);
        check("out_ovf", out_ovf, e.ovf);
        check("out_tag", out_tag, e.tag);
        if (out_ready) void'(sb.pop_front());
      end
      if (in_valid && in_ready) sb.push_back(model(in_data, in_k, in_tag));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded)
  task automatic drive(input logic [BW-1:0] d, input logic [KW-1:0] k, input logic [TW-1:0] t);
    logic acc;
    int   n;
    in_valid = 1'b1;
    in_data  = d;
    in_k     = k;
    in_tag   = t;
    n        = 0;
    acc      = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      step();
      n++;
    end
    if (!acc) check("accept_timeout", 1'b0, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("drain", sb.size() == 0, 1'b1);
    #1;
  endtask

  // After a single accept, out_valid must rise exactly in the 7th following cycle
  task automatic latency_check(input string name, input logic [BW-1:0] exp_data);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      check(name, out_valid, c == 7);
      if (c == 7) check({name, "_data"}, out_data, exp_data);
      step();
    end
  endtask

  initial begin
    logic [BW-1:0] ones;
    logic [BW-1:0] msb;
    logic [BW-1:0] b107_106;
    int sent;
    int cyc;

    ones      = '1;
    msb       = '0;
    msb[107]  = 1'b1;
    b107_106  = msb;
    b107_106[106] = 1'b1;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_k      = '0;
    in_tag    = '0;
    out_ready = 1'b1;

    // Reset state
    step();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_ovf", out_ovf, 1'b0);
    check("rst_out_tag", out_tag, '0);
    step();
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    step();

    // Basic shift with latency measurement
    drive(BW'(1), 7'd0, 8'd0);
    latency_check("latency_k0", BW'(1));

    // Near-MSB, overflow and beyond-width shifts, back to back
    drive(BW'(1), 7'd107, 8'd1);
    drive(msb, 7'd1, 8'd2);
    drive(BW'(3), 7'd106, 8'd3);
    drive(BW'(3), 7'd107, 8'd4);
    drive(ones, 7'd127, 8'd5);
    drive('0, 7'd127, 8'd6);
    drive(BW'(1), 7'd108, 8'd7);
    drive(ones, 7'd64, 8'd8);
    drive(rand_data(), 7'd63, 8'd9);
    drain();

    // Spot-check model against hand-derived results for the near-MSB pair
    check("model_k106", model(BW'(3), 7'd106, 8'd0).data, b107_106);
    check("model_k107_ovf", model(BW'(3), 7'd107, 8'd0).ovf, 1'b1);

    // Backpressure: 20 random beats, consumer stalled for cycles 5..14
    sent = 0;
    cyc  = 0;
    while ((sent < 20) && (cyc < 300)) begin
      out_ready = !(cyc >= 5 && cyc <= 14);
      in_valid  = 1'b1;
      in_data   = rand_data();
      in_k      = KW'($urandom_range(0, 127));
      in_tag    = TW'(sent);
      @(negedge clk);
      if (cyc == 10) begin
        check("bp_in_ready_full", in_ready, 1'b0);
        check("bp_out_valid_held", out_valid, 1'b1);
      end
      if (in_ready) sent++;
      step();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_all_sent", sent, 20);
    drain();

    // Throughput: one result per cycle once the pipe is primed
    for (int c = 0; c < 58; c++) begin
      in_valid = (c < 50);
      in_data  = rand_data();
      in_k     = KW'($urandom_range(0, 127));
      in_tag   = TW'(c);
      @(negedge clk);
      check("tput_out_valid", out_valid, (c >= 7) && (c < 57));
      step();
    end
    in_valid = 1'b0;
    drain();

    // Reset with four beats in flight
    for (int b = 0; b < 4; b++) drive(rand_data() | BW'(1), 7'd3, TW'(100 + b));
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_data", out_data, '0);
    check("mid_rst_out_ovf", out_ovf, 1'b0);
    step();
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);
    for (int c = 0; c < 12; c++) step();
    drive(BW'(5), 7'd2, 8'd200);
    latency_check("post_rst_latency", BW'(20));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lshift_pipe.md
# lshift_pipe

Pipelined, back-pressurable logical left barrel shifter for the FHE datapath; the left-shift counterpart of the combinational right shifter used in modular reduction. It realigns double-width (2×54-bit) operands before reduction and RNS/base-conversion steps, and flags any nonzero bits shifted out. It sits between producer and consumer stages on a valid/ready stream and carries a sideband tag so results can be matched to requests.

## Interface
- BIT_WIDTH, 108: data width in bits (54*2).
- SHIFT_WIDTH, 7: shift-amount width; also the pipeline depth, one stage per amount bit.
- TAG_WIDTH, 8: sideband tag width; the tag passes through unmodified.
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input beat.
- in_data  in  BIT_WIDTH  operand.
- in_k  in  SHIFT_WIDTH  left-shift amount, 0..2^SHIFT_WIDTH-1.
- in_tag  in  TAG_WIDTH  sideband tag.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result beat.
- out_data  out  BIT_WIDTH  (in_data << in_k) truncated to BIT_WIDTH.
- out_ovf  out  1  1 iff any bit discarded by the shift was 1.
- out_tag  out  TAG_WIDTH  tag of this beat.

## Operation
- Stage i (i = 0..SHIFT_WIDTH-1) holds valid, data, remaining k, ovf and tag registers.
- On each load, stage i shifts data left by 2^i when k[i]=1, otherwise it passes data unchanged.
- ovf_next = ovf_prev | (OR of the top 2^i bits of the incoming data when k[i]=1). Stage 0 starts with ovf_prev = 0.
- Shift amounts at or above BIT_WIDTH produce out_data = 0 and out_ovf = |in_data. No special case is needed; this falls out of the stage composition.
- Input handshake: a beat transfers on in_valid & in_ready.
- Output handshake: a beat transfers on out_valid & out_ready.
- Bubble-collapsing flow control: ready_i = !valid_i | ready_(i+1), with ready_SHIFT_WIDTH = out_ready and in_ready = ready_0. The ready chain is combinational.
- A stage loads when its own ready is high. Its valid then becomes the upstream valid.
- Beats never reorder, drop or duplicate. Data is held stable while out_valid & !out_ready.
- Capacity is SHIFT_WIDTH beats. in_ready stays high whenever any downstream slot can advance.
- in_valid may drop at any time without affecting beats in flight. out_valid must not drop until its beat is accepted.
- A simultaneous input accept and output accept in one cycle is legal and sustains a throughput of 1 beat/cycle.
- Reset: all stage valid, data, k, ovf and tag registers go to 0, so out_valid=0, out_data=0, out_ovf=0, out_tag=0, and in_ready=1 from the first cycle after reset.
- Reset mid-operation discards every in-flight beat; nothing partial is emitted afterwards.

## Timing
- Latency is SHIFT_WIDTH cycles (7 by default) from input accept to out_valid, assuming no backpressure.
- Throughput is 1 beat/cycle while out_ready=1.
- With out_ready=0, the pipe fills after SHIFT_WIDTH accepts and in_ready falls in the same cycle the last slot is occupied.
- out_ready rising lets in_ready rise combinationally in that same cycle.
- All outputs except in_ready are registered. in_ready is combinational from out_ready and stage valids, with no combinational path from in_valid.
- The critical path is one 2:1 mux level plus a ≤64-bit OR per stage.

## Structure
- Shared package fhe_acc_pkg holds:
  - LSHIFT_BIT_WIDTH = 108 and LSHIFT_K_WIDTH = 7 defaults;
  - typedef lshift_beat_t, a struct of data, k, ovf and tag.
- One sub-module, lshift_stage, parameterised by stage index. It contains the registered valid/beat and the single-position shift/ovf logic. The top generates SHIFT_WIDTH instances and the ready chain.

## Test plan
- Basic and near-MSB shifts, issued back to back:
  - in_data=1, k=0 -> out_data=1, ovf=0, after 7 cycles.
  - in_data=1, k=107 -> out_data=2^107, ovf=0.
- Overflow cases:
  - in_data=2^107, k=1 -> out_data=0, ovf=1.
  - in_data=0x3, k=106 -> out_data=2^106+2^107, ovf=0.
  - in_data=0x3, k=107 -> out_data=2^107, ovf=1.
- Amounts beyond width:
  - in_data=all-ones, k=127 -> out_data=0, ovf=1.
  - in_data=0, k=127 -> out_data=0, ovf=0.
  - in_data=1, k=108 -> out_data=0, ovf=1.
- Backpressure: stream 20 random beats with tags 0..19 and out_ready low for cycles 5-14.
  - Required: in_ready low once 7 beats are held, all 20 results emerge in tag order matching a reference model, and out_data is stable while stalled.
- Throughput: 50 beats with in_valid and out_ready held high -> exactly 1 result per cycle from cycle 7 on.
- Reset mid-stream: assert rst with 4 beats in flight.
  - Required: out_valid=0, out_data=0, out_ovf=0 immediately; no stale beat after release; in_ready=1 on the first post-reset cycle.
  - A new beat (in_data=5, k=2) then yields 20 after 7 cycles.
